// File: rtl/gray_mon_pkg.sv
// Shared types, default widths and the gray-to-binary helper for the gray_monitor block.
package gray_mon_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Bit i of the binary value is the XOR of all gray bits at or above i.
  function automatic logic [DEF_WIDTH-1:0] gray_to_bin(input logic [DEF_WIDTH-1:0] g);
    logic [DEF_WIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < DEF_WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary decoder, zero latency, no flow control.
// Uses the package helper at the default width, a generic prefix-XOR otherwise.
module gray2bin
  import gray_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  if (WIDTH == DEF_WIDTH) begin : g_def
    assign bin = gray_to_bin(gray);
  end else begin : g_gen
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^gray[WIDTH-1:i];
    end
  end

endmodule

// File: rtl/gray_monitor.sv
// Samples/decodes a gray code on en and classifies each transition; 1-cycle registered latency, no backpressure.
// GRAY_MON_ERRCNT_EN: when defined, err_cnt is a saturating error counter; otherwise err_cnt is tied to 0.
module gray_monitor
  import gray_mon_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clr,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 step_up,
  output logic                 step_dn,
  output logic                 hold,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] bin_dec;
  logic [WIDTH-1:0] prev;
  logic             is_up;
  logic             is_dn;
  logic             is_hold;
  logic             is_bad;

  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] prev_nxt;
  logic             valid_nxt;
  logic             up_nxt;
  logic             dn_nxt;
  logic             hold_nxt;
  logic             err_nxt;
  logic             sticky_nxt;

  gray2bin #(.WIDTH(WIDTH)) u_dec (
    .gray (gray_in),
    .bin  (bin_dec)
  );

  // Modulo-2^WIDTH compare, so the top-to-zero wrap counts as a legal step.
  assign is_up   = (bin_dec == WIDTH'(prev + WIDTH'(1)));
  assign is_dn   = (bin_dec == WIDTH'(prev - WIDTH'(1)));
  assign is_hold = (bin_dec == prev);
  assign is_bad  = !(is_up || is_dn || is_hold);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      prev       <= '0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      step_up    <= 1'b0;
      step_dn    <= 1'b0;
      hold       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      bin_out    <= bin_nxt;
      bin_valid  <= valid_nxt;
      step_up    <= up_nxt;
      step_dn    <= dn_nxt;
      hold       <= hold_nxt;
      err        <= err_nxt;
      err_sticky <= sticky_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = INIT;
    end else if (en) begin
      case (state)
        INIT:    state_nxt = TRACK;
        TRACK:   state_nxt = is_bad ? FAULT : TRACK;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = INIT;
      endcase
    end
  end

  always_comb begin
    prev_nxt   = prev;
    bin_nxt    = bin_out;
    valid_nxt  = bin_valid;
    up_nxt     = 1'b0;
    dn_nxt     = 1'b0;
    hold_nxt   = 1'b0;
    err_nxt    = 1'b0;
    sticky_nxt = err_sticky;
    if (clr) begin
      valid_nxt  = 1'b0;
      sticky_nxt = 1'b0;
    end else if (en) begin
      prev_nxt  = bin_dec;
      bin_nxt   = bin_dec;
      valid_nxt = 1'b1;
      // The first sample after reset/clear only seeds the reference.
      if (state != INIT) begin
        up_nxt   = is_up;
        dn_nxt   = !is_up && is_dn;
        hold_nxt = is_hold;
        err_nxt  = is_bad;
        if (is_bad) sticky_nxt = 1'b1;
      end
    end
  end

`ifdef GRAY_MON_ERRCNT_EN
  logic [ERR_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (err_nxt && !(&cnt_q)) begin
      cnt_q <= cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_gray_monitor.sv
// Directed bench for gray_monitor: vector table plus hand-written saturation and clear sequences.
module tb_gray_monitor;

`ifdef GRAY_MON_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] gray_in;
  logic       clr;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       step_up;
  logic       step_dn;
  logic       hold;
  logic       err;
  logic       err_sticky;
  logic [7:0] err_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  gray_monitor #(.WIDTH(4), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .gray_in    (gray_in),
    .clr        (clr),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .step_up    (step_up),
    .step_dn    (step_dn),
    .hold       (hold),
    .err        (err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] g;
    logic [3:0] bin;
    logic       valid;
    logic       up;
    logic       dn;
    logic       hld;
    logic       er;
    logic       sticky;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic c, input logic [3:0] g,
                     input logic [3:0] b, input logic v, input logic u, input logic d,
                     input logic h, input logic x, input logic s, input logic [7:0] n);
    vec_t t;
    t.rst = r; t.en = e; t.clr = c; t.g = g;
    t.bin = b; t.valid = v; t.up = u; t.dn = d; t.hld = h; t.er = x; t.sticky = s;
    t.cnt = CNT_EN ? n : 8'd0;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic [3:0] g);
    rst = r; en = e; clr = c; gray_in = g;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack_out();
    return {16'd0, bin_out, bin_valid, step_up, step_dn, hold, err, err_sticky, err_cnt};
  endfunction

  logic [3:0] up_gray [16];
  int         err_seen;

  initial begin
    up_gray = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    //  rst en clr g       bin   v  up dn h  err st cnt
    add(1, 1, 0, 4'h5,     4'd0, 0, 0, 0, 0, 0, 0, 8'd0);
    add(1, 1, 0, 4'h5,     4'd0, 0, 0, 0, 0, 0, 0, 8'd0);
    add(0, 1, 0, 4'h0,     4'd0, 1, 0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 16; i++)
      add(0, 1, 0, up_gray[i], 4'((i + 1) % 16), 1, 1, 0, 0, 0, 0, 8'd0);
    add(0, 1, 0, 4'h8,     4'd15, 1, 0, 1, 0, 0, 0, 8'd0);
    add(0, 1, 0, 4'h8,     4'd15, 1, 0, 0, 1, 0, 0, 8'd0);
    add(0, 0, 0, 4'h3,     4'd15, 1, 0, 0, 0, 0, 0, 8'd0);
    add(0, 1, 0, 4'h0,     4'd0,  1, 1, 0, 0, 0, 0, 8'd0);
    add(0, 1, 0, 4'h1,     4'd1,  1, 1, 0, 0, 0, 0, 8'd0);
    add(0, 1, 0, 4'h4,     4'd7,  1, 0, 0, 0, 1, 1, 8'd1);
    add(0, 1, 0, 4'h5,     4'd6,  1, 0, 1, 0, 0, 1, 8'd1);
    add(0, 1, 0, 4'h5,     4'd6,  1, 0, 0, 1, 0, 1, 8'd1);
    add(0, 1, 1, 4'h0,     4'd6,  0, 0, 0, 0, 0, 0, 8'd0);
    add(0, 1, 0, 4'h2,     4'd3,  1, 0, 0, 0, 0, 0, 8'd0);
    add(0, 1, 0, 4'h6,     4'd4,  1, 1, 0, 0, 0, 0, 8'd0);
    add(0, 1, 0, 4'h7,     4'd5,  1, 1, 0, 0, 0, 0, 8'd0);
    add(0, 0, 0, 4'h5,     4'd5,  1, 0, 0, 0, 0, 0, 8'd0);
    add(0, 1, 0, 4'h5,     4'd6,  1, 1, 0, 0, 0, 0, 8'd0);
    add(0, 0, 0, 4'h4,     4'd6,  1, 0, 0, 0, 0, 0, 8'd0);
    add(0, 1, 0, 4'h4,     4'd7,  1, 1, 0, 0, 0, 0, 8'd0);
    add(1, 1, 1, 4'hC,     4'd0,  0, 0, 0, 0, 0, 0, 8'd0);
    add(0, 1, 0, 4'hC,     4'd8,  1, 0, 0, 0, 0, 0, 8'd0);

    rst = 1'b1; en = 1'b0; clr = 1'b0; gray_in = 4'h0;

    foreach (vecs[i]) begin
      vec_t t;
      string nm;
      t = vecs[i];
      step(t.rst, t.en, t.clr, t.g);
      nm = $sformatf("vec%0d", i);
      check(nm, pack_out(),
            {16'd0, t.bin, t.valid, t.up, t.dn, t.hld, t.er, t.sticky, t.cnt});
    end

    // 300 illegal jumps between binary 8 and 0: counter must saturate.
    err_seen = 0;
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 0, (i % 2 == 0) ? 4'h0 : 4'hC);
      if (err) err_seen++;
      if (i == 9)   check("cnt_after_10", 32'(err_cnt), CNT_EN ? 32'd10 : 32'd0);
      if (i == 254) check("cnt_at_255", 32'(err_cnt), CNT_EN ? 32'd255 : 32'd0);
    end
    check("err_pulses_300", 32'(err_seen), 32'd300);
    check("cnt_saturated", 32'(err_cnt), CNT_EN ? 32'd255 : 32'd0);
    check("sticky_after_sat", 32'(err_sticky), 32'd1);
    check("bin_after_sat", 32'(bin_out), 32'd8);

    // clr alone: flags drop, bin_out holds, next sample only seeds.
    step(0, 0, 1, 4'h0);
    check("clr_alone", pack_out(), {16'd0, 4'd8, 1'b0, 5'b0, 8'd0});
    step(0, 1, 0, 4'h1);
    check("seed_after_clr", pack_out(), {16'd0, 4'd1, 1'b1, 5'b0, 8'd0});
    step(0, 1, 0, 4'h2);
    check("illegal_after_seed", pack_out(),
          {16'd0, 4'd3, 1'b1, 4'b0001, 1'b1, CNT_EN ? 8'd1 : 8'd0});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
